// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-requester arbiter.
// Hold-counter width is derived from the hold limit so it just covers 0..MAX_HOLD-1.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int hcnt_w(input int max_hold);
    return (max_hold < 2) ? 1 : $clog2(max_hold);
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8:3 priority encoder; the highest set index wins.
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // Ascending scan: later (higher) indices overwrite lower ones.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter8.sv
// Eight-requester grant/hold arbiter with optional round-robin rotation and hold limit.
// All outputs come straight from registers.
module req_arbiter8
  import arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int MAX_HOLD    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int HCNT_W = hcnt_w(MAX_HOLD);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(MAX_HOLD - 1);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  logic [N_REQ-1:0] masked;
  logic [IDX_W-1:0] req_idx, msk_idx, winner;
  logic             req_vld, msk_vld;
  logic             rel_norm, rel_hold;

  // idx_q doubles as last_idx: the reported owner and the rotation pointer are the same value.
  assign masked = req & ((N_REQ'(1) << idx_q) - N_REQ'(1));

  prio_enc8 u_enc_req (
    .req_i (req),
    .idx_o (req_idx),
    .vld_o (req_vld)
  );

  prio_enc8 u_enc_msk (
    .req_i (masked),
    .idx_o (msk_idx),
    .vld_o (msk_vld)
  );

  assign winner   = (ROUND_ROBIN && msk_vld) ? msk_idx : req_idx;
  assign rel_norm = done || !req[idx_q];
  assign rel_hold = HOLD_EN && (hcnt_q == HCNT_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    hcnt_d  = hcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          state_d = ST_BUSY;
          vld_d   = 1'b1;
          gnt_d   = N_REQ'(1) << winner;
          idx_d   = winner;
          hcnt_d  = '0;
        end else begin
          vld_d = 1'b0;
          gnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (hcnt_q != '1) hcnt_d = hcnt_q + HCNT_W'(1);
        // A timeout is flagged only when the hold limit is the sole reason to let go.
        if (rel_norm || rel_hold) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
          gnt_d   = '0;
          to_d    = !rel_norm;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_req_arbiter8.sv
// Scoreboard bench for req_arbiter8: three configurations share stimulus, each phase checks one.
module tb_req_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;

  logic [7:0] gnt_w  [3];
  logic [2:0] idx_w  [3];
  logic       vld_w  [3];
  logic       to_w   [3];

  // 0: fixed priority, 1: round robin, 2: round robin with MAX_HOLD=4
  req_arbiter8 #(.ROUND_ROBIN(1'b0), .MAX_HOLD(16)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_vld(vld_w[0]), .timeout(to_w[0])
  );
  req_arbiter8 #(.ROUND_ROBIN(1'b1), .MAX_HOLD(16)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_vld(vld_w[1]), .timeout(to_w[1])
  );
  req_arbiter8 #(.ROUND_ROBIN(1'b1), .MAX_HOLD(4)) dut_mh (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_vld(vld_w[2]), .timeout(to_w[2])
  );

  typedef struct {
    int       sel;
    logic     vld;
    logic [2:0] idx;
    logic     to;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the selected DUT must show after the next edge.
  task automatic cyc(input logic [7:0] rq, input logic dn, input logic rs,
                     input int sel, input logic evld, input logic [2:0] eidx, input logic eto);
    exp_t x;
    req  = rq;
    done = dn;
    rst  = rs;
    x.sel = sel; x.vld = evld; x.idx = eidx; x.to = eto;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d dut%0d gnt=%02h idx=%0d vld=%0d to=%0d", txn, e.sel,
               gnt_w[e.sel], idx_w[e.sel], vld_w[e.sel], to_w[e.sel]);
      chk($sformatf("vld%0d_t%0d", e.sel, txn), 32'(vld_w[e.sel]), 32'(e.vld));
      chk($sformatf("idx%0d_t%0d", e.sel, txn), 32'(idx_w[e.sel]), 32'(e.idx));
      chk($sformatf("to%0d_t%0d", e.sel, txn), 32'(to_w[e.sel]), 32'(e.to));
      chk($sformatf("gnt%0d_t%0d", e.sel, txn), 32'(gnt_w[e.sel]),
          e.vld ? (32'd1 << e.idx) : 32'd0);
    end
  end

  int rr_seq[8] = '{6, 5, 4, 3, 2, 1, 0, 6};

  initial begin
    req = 8'h00; done = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Reset and idle with no requests
    cyc(8'h00, 1'b0, 1'b1, 0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b0, 1'b0, 0, 1'b0, 3'd0, 1'b0);

    // Fixed priority: 7 beats 6, done three cycles in, non-owner noise ignored
    cyc(8'h00, 1'b0, 1'b1, 0, 1'b0, 3'd0, 1'b0);
    cyc(8'hC0, 1'b0, 1'b0, 0, 1'b1, 3'd7, 1'b0);
    cyc(8'hC0, 1'b0, 1'b0, 0, 1'b1, 3'd7, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0, 0, 1'b1, 3'd7, 1'b0);
    cyc(8'hC0, 1'b1, 1'b0, 0, 1'b0, 3'd7, 1'b0);
    cyc(8'hC0, 1'b0, 1'b0, 0, 1'b1, 3'd7, 1'b0);
    cyc(8'hC0, 1'b1, 1'b0, 0, 1'b0, 3'd7, 1'b0);

    // Round robin rotation over 8'h7F
    cyc(8'h00, 1'b0, 1'b1, 1, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(8'h7F, 1'b0, 1'b0, 1, 1'b1, 3'(rr_seq[k]), 1'b0);
      cyc(8'h7F, 1'b1, 1'b0, 1, 1'b0, 3'(rr_seq[k]), 1'b0);
    end

    // Owner withdraws its request, next arbitration picks 2
    cyc(8'h00, 1'b0, 1'b1, 1, 1'b0, 3'd0, 1'b0);
    cyc(8'h24, 1'b0, 1'b0, 1, 1'b1, 3'd5, 1'b0);
    cyc(8'h04, 1'b0, 1'b0, 1, 1'b0, 3'd5, 1'b0);
    cyc(8'h04, 1'b0, 1'b0, 1, 1'b1, 3'd2, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1, 1'b0, 3'd2, 1'b0);

    // Hold limit 4: forced release with timeout, then done coinciding with the limit
    cyc(8'h00, 1'b0, 1'b1, 2, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(8'h08, 1'b0, 1'b0, 2, 1'b1, 3'd3, 1'b0);
    cyc(8'h08, 1'b0, 1'b0, 2, 1'b0, 3'd3, 1'b1);
    for (int i = 0; i < 4; i++) cyc(8'h08, 1'b0, 1'b0, 2, 1'b1, 3'd3, 1'b0);
    cyc(8'h08, 1'b1, 1'b0, 2, 1'b0, 3'd3, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 2, 1'b0, 3'd3, 1'b0);

    // Reset while granted, then fresh arbitration from last_idx=0
    cyc(8'h00, 1'b0, 1'b1, 1, 1'b0, 3'd0, 1'b0);
    cyc(8'h80, 1'b0, 1'b0, 1, 1'b1, 3'd7, 1'b0);
    cyc(8'h80, 1'b0, 1'b1, 1, 1'b0, 3'd0, 1'b0);
    cyc(8'h0A, 1'b0, 1'b0, 1, 1'b1, 3'd3, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1, 1'b0, 3'd3, 1'b0);

    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter8.md
# req_arbiter8

Eight-requester arbiter that shares a single downstream resource (bus port, datapath slot) among up to eight clients using the team's 8:3 priority-encoding convention: higher bit index means higher priority. It grants one owner at a time, holds the grant until the owner finishes, withdraws its request or exceeds a hold limit, and optionally rotates priority round-robin for fairness. All outputs are registered and suitable to drive a mux select directly.

## Interface
- `ROUND_ROBIN`, default 1: 0 selects fixed priority (index 7 highest); 1 selects rotating priority.
- `MAX_HOLD`, default 16: maximum number of cycles a grant stays asserted before forced release; 0 disables the limit.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in 8: request vector; bit i is requester i.
- `done` in 1: the current owner has finished; sampled only while `gnt_vld`=1.
- `gnt` out 8: one-hot grant; all zeros when `gnt_vld`=0.
- `gnt_idx` out 3: binary index of the current or last owner.
- `gnt_vld` out 1: a grant is active.
- `timeout` out 1: one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- FSM with two states:
  - ST_IDLE: entered on reset and after every release.
  - ST_BUSY: a grant is held.
- **ST_IDLE, `req`=0:** stay idle; `gnt_vld`=0.
- **ST_IDLE, `req`≠0:** arbitrate, then go to ST_BUSY. Set `gnt_vld`=1, `gnt`=one-hot(winner), `gnt_idx`=winner, `last_idx`=winner, and hold counter `hcnt`=0.
- **Fixed priority:** the winner is the highest set index of `req`.
- **Round robin:** `masked` = `req` & ((1<<`last_idx`)−1).
  - If `masked`≠0, the winner is the highest set index of `masked`.
  - Otherwise, the winner is the highest set index of `req`.
  - Priority therefore rotates downward from the last owner and wraps from 0 to 7.
- **ST_BUSY:** `hcnt` increments each cycle and saturates. The grant is released to ST_IDLE (`gnt`=0, `gnt_vld`=0) when any of these holds:
  - (a) `done`=1;
  - (b) `req[gnt_idx]`=0;
  - (c) `MAX_HOLD`≠0 and `hcnt`=`MAX_HOLD`−1.
- **Forced release:** `timeout`=1 in the cycle of release only when (c) alone causes it.
  - If (a) or (b) coincides with (c), the release is normal and `timeout`=0.
- **`gnt_idx` when idle:** retains the last owner while `gnt_vld`=0.
- **Request changes during a grant:** new or dropped requests from non-owners have no effect until the next arbitration.
- **Reset values:**
  - outputs: `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `timeout`=0;
  - internal: state ST_IDLE, `last_idx`=0, `hcnt`=0.
  - With `last_idx`=0, the first round-robin arbitration reduces to plain highest-index priority.
- **Reset mid-grant:** reset has priority over every other event. All outputs return to reset values at the edge where `rst` is sampled high.
- **X/Z on `req`:** not supported; benches drive only 0/1.

## Timing
- Grant latency: `req` sampled at edge N gives `gnt_vld`=1 after edge N, so visible in cycle N+1.
- Release latency: a release condition sampled at edge M gives `gnt_vld`=0 after edge M.
- Between grants there is a mandatory idle cycle; the earliest regrant follows edge M+1. The back-to-back gap is exactly one cycle with `gnt_vld`=0.
- With `MAX_HOLD`=H, `gnt_vld` stays high for at most H consecutive cycles.
- No combinational path from inputs to outputs.

## Structure
- Shared package `arb_pkg`:
  - `N_REQ`=8, `IDX_W`=3;
  - state enum `ST_IDLE`/`ST_BUSY`;
  - hold-counter width derived from `MAX_HOLD`.
- Sub-module `prio_enc8`: combinational 8:3 priority encoder with valid output (highest index wins).
  - Instantiated twice: once on `req`, once on `masked`.
  - Round-robin select: use the `masked` result if its valid is set, else the `req` result.
- Top level holds the FSM, `last_idx`, `hcnt` and the output registers.

## Test plan
- Reset, then `req`=8'h00 for 10 cycles -> `gnt`=0, `gnt_vld`=0, `gnt_idx`=0, `timeout`=0 throughout.
- `ROUND_ROBIN`=0, `req`=8'b11000000 held, `done` pulsed 3 cycles after grant -> `gnt`=8'h80, `gnt_idx`=7; one idle cycle; regrant to 7.
- `ROUND_ROBIN`=1, `req`=8'h7F held, `done` pulsed one cycle after each grant -> `gnt_idx` sequence 6,5,4,3,2,1,0,6, each separated by a single idle cycle.
- `req`=8'b00100100, grant to 5, then clear `req[5]` -> release at next edge; after one idle cycle grant to 2 (`gnt`=8'h04).
- `MAX_HOLD`=4, `req`=8'h08 held, no `done` -> `gnt_vld` high exactly 4 cycles, `timeout`=1 for 1 cycle at the release edge, one idle cycle, regrant to 3.
- Assert `rst` while granted to 7 -> all outputs 0 at the next edge. Then `req`=8'h0A -> grant to 3 (`gnt`=8'h08) with 1-cycle latency.
